// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer and its display interface.
package countdown_pkg;

    localparam int VALUE_W = 5;
    localparam logic [VALUE_W-1:0] BLANK_CODE = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Clamp a requested preload so the decoder never sees more than two digits.
    function automatic logic [VALUE_W-1:0] satLoad(input logic [VALUE_W-1:0] req,
                                                   input int unsigned maxCount);
        logic [VALUE_W-1:0] maxVal;
        maxVal = VALUE_W'(maxCount);
        return (req > maxVal) ? maxVal : req;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector; history clears on reset so a level held
// high through reset reports an edge on the first cycle afterwards.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable 0..MAX_COUNT countdown timer feeding the two-digit display decoder.
// Optional feature: define COUNTDOWN_BLINK_DONE_EN to blink the display in DONE.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_COUNT = 15,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] load_val,
    input  logic               load,
    input  logic               start,
    input  logic               pause,
    output logic [VALUE_W-1:0] value,
    output logic               running,
    output logic               done
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               loadRise, startRise, pauseRise;
    logic               tick;

    rise_detect u_loadEdge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (load),
        .rise_o (loadRise)
    );

    rise_detect u_startEdge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (start),
        .rise_o (startRise)
    );

    rise_detect u_pauseEdge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (pause),
        .rise_o (pauseRise)
    );

`ifdef COUNTDOWN_BLINK_DONE_EN
    localparam int BLINK_W = $clog2(2 * BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV);

    logic [BLINK_W-1:0] blink_q, blink_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    logic unusedBlinkDiv;
    assign unusedBlinkDiv = ^BLINK_DIV;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            value_q   <= '0;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tick = (pre_q == PRE_LAST);

    // Event priority: load, then pause, then start, then the prescaler tick.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_BLINK_DONE_EN
        blink_d = '0;
`endif
        if (loadRise) begin
            state_d = IDLE;
            value_d = satLoad(load_val, MAX_COUNT);
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startRise && (value_q != '0)) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    if (pauseRise) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        pre_d   = '0;
                        value_d = value_q - VALUE_W'(1);
                        if (value_q == VALUE_W'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    if (startRise) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
`ifdef COUNTDOWN_BLINK_DONE_EN
                    blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
                    value_d = (blink_d >= BLINK_HALF) ? BLANK_CODE : '0;
`else
                    value_d = '0;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    assign value   = value_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV=4, BLINK_DIV=3.
module tb_countdown_timer;

    typedef struct {
        logic       rst;
        logic       load;
        logic [4:0] loadVal;
        logic       start;
        logic       pause;
        logic [4:0] expValue;
        logic       expRunning;
        logic       expDone;
    } vector_t;

`ifdef COUNTDOWN_BLINK_DONE_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] load_val = '0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [4:0] value;
    logic       running;
    logic       done;

    int         testsRun = 0;
    int         testsFailed = 0;
    vector_t    vecs[$];

    countdown_timer #(
        .TICK_DIV  (4),
        .MAX_COUNT (15),
        .BLINK_DIV (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_val (load_val),
        .load     (load),
        .start    (start),
        .pause    (pause),
        .value    (value),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic r, input logic l, input logic [4:0] lv,
                                 input logic s, input logic p);
        @(negedge clk);
        rst      = r;
        load     = l;
        load_val = lv;
        start    = s;
        pause    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expV,
                               input logic expR, input logic expD);
        testsRun++;
        if (value !== expV || running !== expR || done !== expD) begin
            testsFailed++;
            $display("[TB] FAIL %s: got value=%0d running=%0b done=%0b, expected value=%0d running=%0b done=%0b",
                     name, value, running, done, expV, expR, expD);
        end
    endtask

    task automatic addVec(input logic r, input logic l, input logic [4:0] lv,
                          input logic s, input logic p,
                          input logic [4:0] ev, input logic er, input logic ed);
        vector_t v;
        v.rst = r; v.load = l; v.loadVal = lv; v.start = s; v.pause = p;
        v.expValue = ev; v.expRunning = er; v.expDone = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset, ignored start at zero, loads, full countdown, DONE lockout, saturation, mid-run load.
        addVec(1, 0,  0, 0, 0,  0, 0, 0);
        addVec(0, 0,  0, 1, 0,  0, 0, 0);
        addVec(0, 1,  9, 0, 0,  9, 0, 0);
        addVec(0, 0,  9, 0, 0,  9, 0, 0);
        addVec(0, 1,  3, 0, 0,  3, 0, 0);
        addVec(0, 0,  3, 1, 0,  3, 1, 0);
        addVec(0, 0,  3, 1, 0,  3, 1, 0);
        addVec(0, 0,  3, 0, 0,  3, 1, 0);
        addVec(0, 0,  3, 0, 0,  3, 1, 0);
        addVec(0, 0,  3, 0, 0,  2, 1, 0);
        addVec(0, 0,  3, 0, 0,  2, 1, 0);
        addVec(0, 0,  3, 0, 0,  2, 1, 0);
        addVec(0, 0,  3, 0, 0,  2, 1, 0);
        addVec(0, 0,  3, 0, 0,  1, 1, 0);
        addVec(0, 0,  3, 0, 0,  1, 1, 0);
        addVec(0, 0,  3, 0, 0,  1, 1, 0);
        addVec(0, 0,  3, 0, 0,  1, 1, 0);
        addVec(0, 0,  3, 0, 0,  0, 0, 1);
        addVec(0, 0,  3, 0, 0,  0, 0, 0);
        addVec(0, 0,  3, 1, 0,  0, 0, 0);
        addVec(0, 0,  3, 0, 1,  BLINK_ON ? 5'd31 : 5'd0, 0, 0);
        addVec(0, 1, 20, 0, 0, 15, 0, 0);
        addVec(0, 0, 20, 1, 0, 15, 1, 0);
        addVec(0, 0, 20, 0, 0, 15, 1, 0);
        addVec(0, 1,  7, 0, 0,  7, 0, 0);
        addVec(0, 0,  7, 0, 0,  7, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].loadVal, vecs[i].start, vecs[i].pause);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValue, vecs[i].expRunning, vecs[i].expDone);
        end

        // Pause two cycles into a period, hold, then resume and finish the partial period.
        applyStimulus(0, 1, 5, 0, 0); checkOutput("pr_load", 5, 0, 0);
        applyStimulus(0, 0, 5, 1, 0); checkOutput("pr_start", 5, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("pr_run1", 5, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("pr_run2", 5, 1, 0);
        applyStimulus(0, 0, 5, 0, 1); checkOutput("pr_pause", 5, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 5, 0, k[0]);
            checkOutput($sformatf("pr_frozen%0d", k), 5, 0, 0);
        end
        applyStimulus(0, 0, 5, 1, 0); checkOutput("pr_resume", 5, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("pr_resume1", 5, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("pr_resume2", 4, 1, 0);

        // Pause on the tick cycle: no decrement, and the tick fires right after resume.
        applyStimulus(0, 0, 5, 0, 0); checkOutput("co_run1", 4, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("co_run2", 4, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("co_run3", 4, 1, 0);
        applyStimulus(0, 0, 5, 0, 1); checkOutput("co_pause_tick", 4, 0, 0);
        applyStimulus(0, 0, 5, 1, 0); checkOutput("co_resume", 4, 1, 0);
        applyStimulus(0, 0, 5, 0, 0); checkOutput("co_tick", 3, 1, 0);

        // Reset mid-run, then a load held high through reset.
        applyStimulus(1, 0, 5, 0, 0); checkOutput("rst_midrun", 0, 0, 0);
        applyStimulus(1, 1, 6, 0, 0); checkOutput("rst_held_load", 0, 0, 0);
        applyStimulus(0, 1, 6, 0, 0); checkOutput("load_after_rst", 6, 0, 0);

        // Count 1 into DONE and watch the display for several blink periods.
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0); checkOutput("dn_load", 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0); checkOutput("dn_start", 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("dn_pretick", 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0); checkOutput("dn_enter", 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput($sformatf("dn_hold%0d", k),
                        (BLINK_ON && ((k % 6) >= 3)) ? 5'd31 : 5'd0, 0, 0);
        end
        applyStimulus(0, 1, 4, 0, 0); checkOutput("dn_reload", 4, 0, 0);
        applyStimulus(0, 0, 4, 0, 0); checkOutput("dn_noblink", 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
